// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and sizing helpers for the matmul engine.
//   state_t   : controller state encoding
//   dim_width : width of a dimension field able to hold 0..max_dim
//   acc_width : accumulator width that cannot overflow for a max_dim-long dot product
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_DRAIN,
    ST_WR,
    ST_DONE
  } state_t;

  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int acc_width(input int data_width, input int max_dim);
    return 2 * data_width + $clog2(max_dim);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: signed multiply-accumulate with clear/enable and result
// formatting for the Z write port.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   acc_clr      : zero the accumulator (wins over acc_en)
//   acc_en       : add a*b to the accumulator
//   a, b         : signed operands straight from the X/Y BRAMs
//   wr_en        : a Z element is being written this cycle (result in use)
//   sat_clr      : clear the sticky saturation flag (new run accepted)
//   result       : accumulator formatted to DATA_WIDTH
//   sat_flag     : sticky, set when a written result had to be clipped
// Build option MATMUL_SAT_EN: clamp result to the DATA_WIDTH signed range;
// without it the result is the low DATA_WIDTH bits and sat_flag stays 0.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 70
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  acc_clr,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  wr_en,
  input  logic                  sat_clr,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat_flag
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic                        sat_hit;

  // Operands widened first so the full-width product is exact.
  assign a_ext    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + prod_ext;
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    result  = acc_q[DATA_WIDTH-1:0];
    sat_hit = 1'b0;
    if (acc_q > MAX_V) begin
      result  = MAX_V[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (acc_q < MIN_V) begin
      result  = MIN_V[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end
  end
`else
  assign result  = acc_q[DATA_WIDTH-1:0];
  assign sat_hit = 1'b0;
`endif

  // Only clips that actually reach the Z port count.
  always_comb begin
    sat_d = sat_q;
    if (sat_clr) begin
      sat_d = 1'b0;
    end else if (wr_en && sat_hit) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: runtime-dimensioned signed matrix multiply Z = X * Y
// (row-major) between 1-cycle-latency X/Y read BRAMs and a Z write port.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start, cfg_m/k/n      : run request and dimensions, sampled in IDLE only
//   busy, done, err       : status; done is a 1-cycle pulse, err valid with it
//   sat_flag              : sticky per run, a Z element was clipped
//   x_addr/x_dout, y_addr/y_dout : BRAM read ports (data one cycle after addr)
//   z_addr, z_din, z_wr_en       : Z write port
// Build option MATMUL_SAT_EN (in matmul_mac): saturating Z results.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_DIM    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [dim_width(MAX_DIM)-1:0] cfg_m,
  input  logic [dim_width(MAX_DIM)-1:0] cfg_k,
  input  logic [dim_width(MAX_DIM)-1:0] cfg_n,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          sat_flag,
  output logic [ADDR_WIDTH-1:0]         x_addr,
  input  logic [DATA_WIDTH-1:0]         x_dout,
  output logic [ADDR_WIDTH-1:0]         y_addr,
  input  logic [DATA_WIDTH-1:0]         y_dout,
  output logic [ADDR_WIDTH-1:0]         z_addr,
  output logic [DATA_WIDTH-1:0]         z_din,
  output logic                          z_wr_en
);

  localparam int DIM_W = dim_width(MAX_DIM);
  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_DIM);
  localparam int DM = 0;
  localparam int DK = 1;
  localparam int DN = 2;
  localparam logic [DIM_W-1:0]      DIM_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0]      DIM_MAX  = DIM_W'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  if (MAX_DIM * MAX_DIM > 2 ** ADDR_WIDTH) begin : g_addr_too_narrow
    $error("matmul_engine: ADDR_WIDTH too small for MAX_DIM*MAX_DIM elements");
  end

  state_t                       state_q, state_d;
  logic [2:0][DIM_W-1:0]        dim_q, dim_d;
  logic [DIM_W-1:0]             i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic [ADDR_WIDTH-1:0]        x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0]        y_addr_q, y_addr_d;
  logic [ADDR_WIDTH-1:0]        z_addr_q, z_addr_d;
  logic [ADDR_WIDTH-1:0]        x_row_q, x_row_d;   // i*K, start of row i of X
  logic                         err_q, err_d;
  logic                         rd_dly_q, rd_dly_d; // BRAM data valid this cycle
  logic                         acc_clr;
  logic                         sat_clr;
  logic [2:0]                   dim_bad;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dim_check
    assign dim_bad[gi] = (dim_q[gi] == '0) || (dim_q[gi] > DIM_MAX);
  end

  always_comb begin
    state_d  = state_q;
    dim_d    = dim_q;
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;
    z_addr_d = z_addr_q;
    x_row_d  = x_row_q;
    err_d    = err_q;
    rd_dly_d = (state_q == ST_RD);
    acc_clr  = 1'b0;
    sat_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dim_d[DM] = cfg_m;
          dim_d[DK] = cfg_k;
          dim_d[DN] = cfg_n;
          err_d     = 1'b0;
          sat_clr   = 1'b1;
          state_d   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (|dim_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_clr  = 1'b1;
          i_d      = '0;
          j_d      = '0;
          kk_d     = '0;
          x_addr_d = '0;
          y_addr_d = '0;
          z_addr_d = '0;
          x_row_d  = '0;
          state_d  = ST_RD;
        end
      end

      // Walk X along the row (+1) and Y down the column (+N).
      ST_RD: begin
        if (kk_q == dim_q[DK] - DIM_ONE) begin
          kk_d    = '0;
          state_d = ST_DRAIN;
        end else begin
          kk_d     = kk_q + DIM_ONE;
          x_addr_d = x_addr_q + ADDR_ONE;
          y_addr_d = y_addr_q + ADDR_WIDTH'(dim_q[DN]);
        end
      end

      ST_DRAIN: begin
        state_d = ST_WR;
      end

      // Write Z, then set up read pointers for the next element.
      ST_WR: begin
        acc_clr  = 1'b1;
        z_addr_d = z_addr_q + ADDR_ONE;
        if (j_q == dim_q[DN] - DIM_ONE) begin
          j_d = '0;
          if (i_q == dim_q[DM] - DIM_ONE) begin
            state_d = ST_DONE;
          end else begin
            i_d      = i_q + DIM_ONE;
            x_row_d  = x_row_q + ADDR_WIDTH'(dim_q[DK]);
            x_addr_d = x_row_q + ADDR_WIDTH'(dim_q[DK]);
            y_addr_d = '0;
            state_d  = ST_RD;
          end
        end else begin
          j_d      = j_q + DIM_ONE;
          x_addr_d = x_row_q;
          y_addr_d = ADDR_WIDTH'(j_q) + ADDR_ONE;
          state_d  = ST_RD;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dim_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      kk_q     <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      z_addr_q <= '0;
      x_row_q  <= '0;
      err_q    <= 1'b0;
      rd_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dim_q    <= dim_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kk_q     <= kk_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      z_addr_q <= z_addr_d;
      x_row_q  <= x_row_d;
      err_q    <= err_d;
      rd_dly_q <= rd_dly_d;
    end
  end

  matmul_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .acc_clr  (acc_clr),
    .acc_en   (rd_dly_q),
    .a        (x_dout),
    .b        (y_dout),
    .wr_en    (z_wr_en),
    .sat_clr  (sat_clr),
    .result   (z_din),
    .sat_flag (sat_flag)
  );

  // Decoded straight from the state flop so reset removes them at once.
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign z_wr_en = (state_q == ST_WR);
  assign err     = err_q;
  assign x_addr  = x_addr_q;
  assign y_addr  = y_addr_q;
  assign z_addr  = z_addr_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Testbench for matmul_engine: BRAM models with 1-cycle read latency, a
// reference model computing Z from X/Y with plain integer arithmetic, and a
// monitor comparing every Z write and every done pulse against it.
// Build with or without MATMUL_SAT_EN; expectations follow the same macro.
module tb_matmul_engine;

  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int MAXD = 64;
  localparam int DIMW = $clog2(MAXD + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [DIMW-1:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic            busy, done, err, sat_flag, z_wr_en;
  logic [AW-1:0]   x_addr, y_addr, z_addr;
  logic [DW-1:0]   x_dout, y_dout, z_din;

  logic [DW-1:0] x_mem [0:(1<<AW)-1];
  logic [DW-1:0] y_mem [0:(1<<AW)-1];
  logic [DW-1:0] z_mem [0:(1<<AW)-1];

  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  bit  exp_err;
  bit  exp_sat;
  int  exp_lat;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, wr_cnt = 0;

  matmul_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(MAXD)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .busy(busy), .done(done), .err(err), .sat_flag(sat_flag),
    .x_addr(x_addr), .x_dout(x_dout), .y_addr(y_addr), .y_dout(y_dout),
    .z_addr(z_addr), .z_din(z_din), .z_wr_en(z_wr_en)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    x_dout <= x_mem[x_addr];
    y_dout <= y_mem[y_addr];
    if (z_wr_en) begin
      z_mem[z_addr] <= z_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: Z[i][j] = sum_k X[i][k]*Y[k][j], then wrap or clamp.
  task automatic build_expect(input int m, input int k, input int n);
    longint s;
    wr_t    e;
    exp_q.delete();
    exp_sat = 1'b0;
    exp_err = (m == 0 || k == 0 || n == 0 || m > MAXD || k > MAXD || n > MAXD);
    if (!exp_err) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          s = 0;
          for (int kk = 0; kk < k; kk++)
            s += longint'($signed(x_mem[i*k+kk])) * longint'($signed(y_mem[kk*n+j]));
          e.addr = i * n + j;
`ifdef MATMUL_SAT_EN
          if (s > 64'sd2147483647) begin
            s = 64'sd2147483647; exp_sat = 1'b1;
          end else if (s < -64'sd2147483648) begin
            s = -64'sd2147483648; exp_sat = 1'b1;
          end
`endif
          e.data = s[DW-1:0];
          exp_q.push_back(e);
        end
      end
    end
    exp_lat = exp_err ? 2 : 2 + m * n * (k + 2);
  endtask

  // Monitor: cyc counts busy cycles since the start edge (CHECK = 1).
  always @(negedge clock) begin
    wr_t e;
    if (reset) begin
      cyc = 0;
    end else begin
      if (busy) cyc++; else cyc = 0;
      if (z_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", longint'(z_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("z_addr", longint'(z_addr), longint'(e.addr));
          chk("z_din", longint'($signed(z_din)), longint'($signed(e.data)));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_err", longint'(err), longint'(exp_err));
        chk("done_sat_flag", longint'(sat_flag), longint'(exp_sat));
        chk("done_latency", longint'(cyc), longint'(exp_lat));
      end
    end
  end

  // One run; poke>0 re-pulses start with other dims mid-run, abort_at>0
  // asserts reset that many cycles after CHECK.
  task automatic run(input int m, input int k, input int n,
                     input int poke, input int abort_at, input bit abort_wr);
    int  d0, w0;
    bit  got;
    build_expect(m, k, n);
    d0 = done_cnt;
    w0 = wr_cnt;
    @(negedge clock);
    cfg_m = DIMW'(m); cfg_k = DIMW'(k); cfg_n = DIMW'(n); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("err_clear_on_start", longint'(err), 0);
    chk("busy_in_check", longint'(busy), 1);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clock);
      #2;
      chk("wr_before_abort", longint'(z_wr_en), longint'(abort_wr));
      reset = 1'b1;
      #1;
      chk("abort_z_wr_en", longint'(z_wr_en), 0);
      chk("abort_busy", longint'(busy), 0);
      chk("abort_done", longint'(done), 0);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      repeat (4) @(posedge clock);
      #2;
      chk("abort_no_done", longint'(done_cnt - d0), 0);
      $display("run m=%0d k=%0d n=%0d aborted at cycle %0d writes=%0d",
               m, k, n, abort_at + 1, wr_cnt - w0);
      return;
    end
    if (poke > 0) begin
      repeat (poke) @(negedge clock);
      cfg_m = 3; cfg_k = 3; cfg_n = 3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < exp_lat + 20; c++) begin
      @(posedge clock);
      #2;
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", longint'(got), 1);
    @(posedge clock);
    #2;
    chk("idle_busy", longint'(busy), 0);
    chk("idle_done", longint'(done), 0);
    repeat (3) @(posedge clock);
    #2;
    chk("writes_left", longint'(exp_q.size()), 0);
    chk("single_done", longint'(done_cnt - d0), 1);
    $display("run m=%0d k=%0d n=%0d err=%0d sat=%0d writes=%0d cycles=%0d",
             m, k, n, err, sat_flag, wr_cnt - w0, exp_lat);
  endtask

  initial begin
    int w0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_z_wr_en", longint'(z_wr_en), 0);
    chk("rst_x_addr", longint'(x_addr), 0);
    chk("rst_y_addr", longint'(y_addr), 0);
    chk("rst_z_addr", longint'(z_addr), 0);
    @(negedge clock);
    reset = 1'b0;

    // 2x2x2
    x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3; x_mem[3] = 4;
    y_mem[0] = 5; y_mem[1] = 6; y_mem[2] = 7; y_mem[3] = 8;
    run(2, 2, 2, 0, 0, 1'b0);
    chk("t1_z00", longint'($signed(z_mem[0])), 19);
    chk("t1_z01", longint'($signed(z_mem[1])), 22);
    chk("t1_z10", longint'($signed(z_mem[2])), 43);
    chk("t1_z11", longint'($signed(z_mem[3])), 50);
    chk("t1_err", longint'(err), 0);

    // 3x1 by 1x2, negative operands
    x_mem[0] = -32'sd1; x_mem[1] = 32'sd2; x_mem[2] = -32'sd3;
    y_mem[0] = 32'sd4;  y_mem[1] = -32'sd5;
    w0 = wr_cnt;
    run(3, 1, 2, 0, 0, 1'b0);
    chk("t2_writes", longint'(wr_cnt - w0), 6);
    chk("t2_z0", longint'($signed(z_mem[0])), -4);
    chk("t2_z1", longint'($signed(z_mem[1])), 5);
    chk("t2_z2", longint'($signed(z_mem[2])), 8);
    chk("t2_z3", longint'($signed(z_mem[3])), -10);
    chk("t2_z4", longint'($signed(z_mem[4])), -12);
    chk("t2_z5", longint'($signed(z_mem[5])), 15);

    // illegal dimensions
    w0 = wr_cnt;
    run(2, 0, 2, 0, 0, 1'b0);
    chk("t3a_err", longint'(err), 1);
    run(MAXD + 1, 2, 2, 0, 0, 1'b0);
    chk("t3b_err", longint'(err), 1);
    chk("t3_no_writes", longint'(wr_cnt - w0), 0);

    // largest positive squared
    x_mem[0] = 32'h7FFF_FFFF;
    y_mem[0] = 32'h7FFF_FFFF;
    run(1, 1, 1, 0, 0, 1'b0);
`ifdef MATMUL_SAT_EN
    chk("t4_z", longint'($signed(z_mem[0])), 2147483647);
    chk("t4_sat", longint'(sat_flag), 1);
`else
    chk("t4_z", longint'($signed(z_mem[0])), 1);
    chk("t4_sat", longint'(sat_flag), 0);
`endif

    // start and cfg disturbed mid-run
    x_mem[0] = 2; x_mem[1] = -1; x_mem[2] = 0; x_mem[3] = 3;
    y_mem[0] = 4; y_mem[1] = 1;  y_mem[2] = -2; y_mem[3] = 5;
    run(2, 2, 2, 4, 0, 1'b0);
    chk("t5_z00", longint'($signed(z_mem[0])), 10);
    chk("t5_z01", longint'($signed(z_mem[1])), -3);
    chk("t5_z10", longint'($signed(z_mem[2])), -6);
    chk("t5_z11", longint'($signed(z_mem[3])), 15);
    chk("t5_sat_cleared", longint'(sat_flag), 0);

    // 4x4x4: abort mid-RD, abort during a write, then a clean rerun
    for (int a = 0; a < 16; a++) begin
      x_mem[a] = DW'(a % 7 - 3);
      y_mem[a] = DW'(5 - a % 9);
    end
    run(4, 4, 4, 0, 20, 1'b0);
    run(4, 4, 4, 0, 6, 1'b1);
    run(4, 4, 4, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
